input_ram_arb: RTL and testbench

Arbiter and write sequencer for the 784×1-bit input-image RAM. It sits between two requesters and the single RAM port:
- the UART byte loader, which delivers packed pixel bytes;
- the inference core, which reads one pixel bit per address.

It unpacks each accepted byte into eight single-bit RAM writes at a running pixel pointer. It grants the core exclusive read ownership of the RAM between bytes, and flags each completed frame.

---
 rtl/input_ram_arb.sv | 188 ++++++++++++++++++
 tb/tb_input_ram_arb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_ram_arb.sv
// -----------------------------------------------------------------------------
// input_ram_arb
//
// Arbiter and write sequencer for the single-port 1-bit input-image RAM.
// Two requesters share the RAM port:
//   * the UART byte loader: each accepted byte is unpacked into eight 1-bit
//     writes at a running pixel pointer. Bit 0 goes to the lowest address.
//   * the inference core: it is given exclusive read ownership of the RAM
//     between bytes.
// The loader and the core take turns round-robin when both ask in IDLE.
// ld_frame_done pulses once after the last pixel of a frame has been written.
//
// Optional feature (compile-time macro):
//   ARB_FRAME_LOCK_EN - the core is granted only on frame boundaries
//                       (pix_cnt == 0). A partially loaded image is never
//                       exposed to the core.
//
// Parameters:
//   ADDR_WIDTH  RAM address width
//   NUM_PIXELS  pixels per frame (multiple of 8, <= 2**ADDR_WIDTH)
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   ld_req         loader has a byte (held until ld_gnt)
//   ld_byte        packed pixel byte, stable while ld_req is high
//   ld_gnt         one-cycle pulse: byte captured
//   ld_frame_done  one-cycle pulse: last pixel of the frame written
//   core_req       core requests read ownership (level)
//   core_addr      core read address
//   core_gnt       core owns the RAM
//   core_q         RAM read data passed through to the core
//   ram_addr       RAM address
//   ram_data       RAM write data
//   ram_we         RAM write enable
//   ram_q          RAM read data (registered one cycle after ram_addr)
//   busy           controller not idle
// -----------------------------------------------------------------------------
module input_ram_arb #(
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_PIXELS = 784
) (
    input  logic                  clk,
    input  logic                  rst,
    // loader side
    input  logic                  ld_req,
    input  logic [7:0]            ld_byte,
    output logic                  ld_gnt,
    output logic                  ld_frame_done,
    // core side
    input  logic                  core_req,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    output logic                  core_gnt,
    output logic                  core_q,
    // RAM port
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_data,
    output logic                  ram_we,
    input  logic                  ram_q,
    // status
    output logic                  busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UNPACK = 2'd1;
    localparam logic [1:0] S_CORE   = 2'd2;

    // last_owner encoding: who was served most recently
    localparam logic OWN_LOADER = 1'b0;
    localparam logic OWN_CORE   = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(NUM_PIXELS - 1);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] pix_cnt;
    logic [2:0]            bit_cnt;
    logic [7:0]            byte_reg;
    logic                  last_owner;
    logic                  ld_gnt_r;
    logic                  frame_done_r;

    logic                  core_ok;
    logic                  grant_ld;
    logic                  grant_core;
    logic                  unpack_last;
    logic                  pix_last;

`ifdef ARB_FRAME_LOCK_EN
    // Core may only take the RAM when no frame is partially loaded.
    assign core_ok = core_req && (pix_cnt == '0);
`else
    assign core_ok = core_req;
`endif

    assign unpack_last = (bit_cnt == 3'd7);
    assign pix_last    = (pix_cnt == LAST_PIX);

    // -------------------------------------------------------------------------
    // Arbitration and next state
    // -------------------------------------------------------------------------
    always_comb begin
        grant_ld   = 1'b0;
        grant_core = 1'b0;
        state_nxt  = state;
        case (state)
            S_IDLE: begin
                if (ld_req && core_ok) begin
                    // tie: serve whoever did not go last
                    if (last_owner == OWN_CORE) grant_ld   = 1'b1;
                    else                        grant_core = 1'b1;
                end else if (ld_req) begin
                    grant_ld = 1'b1;
                end else if (core_ok) begin
                    grant_core = 1'b1;
                end

                if (grant_ld)        state_nxt = S_UNPACK;
                else if (grant_core) state_nxt = S_CORE;
            end
            S_UNPACK: begin
                // a byte always runs to completion; core_req waits for IDLE
                if (unpack_last) state_nxt = S_IDLE;
            end
            S_CORE: begin
                if (!core_req) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counters, byte capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            pix_cnt      <= '0;
            bit_cnt      <= 3'd0;
            byte_reg     <= 8'd0;
            last_owner   <= OWN_CORE;   // loader wins the first tie
            ld_gnt_r     <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state        <= state_nxt;
            ld_gnt_r     <= grant_ld;   // pulse lines up with the first write
            frame_done_r <= 1'b0;

            if (grant_ld) byte_reg <= ld_byte;

            if (state == S_UNPACK) begin
                bit_cnt      <= bit_cnt + 3'd1;   // 7 -> 0 wraps naturally
                pix_cnt      <= pix_last ? '0 : pix_cnt + ADDR_WIDTH'(1);
                frame_done_r <= pix_last;
                if (unpack_last) last_owner <= OWN_LOADER;
            end

            if ((state == S_CORE) && !core_req) last_owner <= OWN_CORE;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded straight from state so reset clears them at once
    // -------------------------------------------------------------------------
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_data = 1'b0;
        case (state)
            S_UNPACK: begin
                ram_we   = 1'b1;
                ram_addr = pix_cnt;
                ram_data = byte_reg[bit_cnt];
            end
            S_CORE: begin
                ram_addr = core_addr;
            end
            default: ;
        endcase
    end

    assign ld_gnt        = ld_gnt_r;
    assign ld_frame_done = frame_done_r;
    assign core_gnt      = (state == S_CORE);
    assign core_q        = ram_q;
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_input_ram_arb.sv
// -----------------------------------------------------------------------------
// tb_input_ram_arb
//
// Self-checking bench for input_ram_arb. Expected RAM writes {addr,data} are
// queued as each byte is offered and popped by a monitor on every write cycle.
// Grant, busy and frame-done timing are checked cycle by cycle. A 1-bit RAM
// model with a registered read port provides ram_q.
// -----------------------------------------------------------------------------
module tb_input_ram_arb;

    localparam int AW   = 10;
    localparam int NPIX = 784;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_req;
    logic [7:0]    ld_byte;
    logic          ld_gnt;
    logic          ld_frame_done;
    logic          core_req;
    logic [AW-1:0] core_addr;
    logic          core_gnt;
    logic          core_q;
    logic [AW-1:0] ram_addr;
    logic          ram_data;
    logic          ram_we;
    logic          ram_q;
    logic          busy;

    input_ram_arb #(.ADDR_WIDTH(AW), .NUM_PIXELS(NPIX)) dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_byte(ld_byte), .ld_gnt(ld_gnt),
        .ld_frame_done(ld_frame_done),
        .core_req(core_req), .core_addr(core_addr), .core_gnt(core_gnt),
        .core_q(core_q),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
        .ram_q(ram_q), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM model: write and registered read on the same edge
    logic mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ptr = 0;
    int fd_cnt  = 0;
    logic [AW:0] sb_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // write monitor + frame-done timing
    initial begin : mon
        logic        prev_last_wr;
        logic [AW:0] e;
        prev_last_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ld_frame_done) begin
                    fd_cnt++;
                    chk("fd_timing", prev_last_wr, 1);
                end
                prev_last_wr = ram_we && (ram_addr == AW'(NPIX-1));
                if (ram_we) begin
                    if (sb_q.size() == 0) begin
                        chk("wr_unexpected", ram_addr, '1);
                    end else begin
                        e = sb_q.pop_front();
                        chk("wr_addr", ram_addr, e[AW:1]);
                        chk("wr_data", ram_data, e[0]);
                    end
                end
            end else begin
                prev_last_wr = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic push_exp(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sb_q.push_back({AW'(exp_ptr), b[i]});
            exp_ptr = (exp_ptr == NPIX-1) ? 0 : exp_ptr + 1;
        end
    endtask

    // pulse reset mid-cycle and confirm outputs clear immediately
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_ld_gnt",   ld_gnt, 0);
        chk("rst_fd",       ld_frame_done, 0);
        chk("rst_core_gnt", core_gnt, 0);
        chk("rst_ram_we",   ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_data", ram_data, 0);
        chk("rst_busy",     busy, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_ptr = 0;
    endtask

    // Offer one byte with exact cycle checks. core_at: negedge index at which
    // core_req is raised (0 = together with ld_req), <0 = never.
    task automatic byte_core(input logic [7:0] b, input int core_at);
        int kmax;
        push_exp(b, 8);
        kmax = (core_at >= 0) ? 10 : 9;
        ld_byte = b;
        ld_req  = 1'b1;
        if (core_at == 0) core_req = 1'b1;
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            chk("ld_gnt",   ld_gnt,   k == 1);
            chk("ram_we",   ram_we,   k <= 8);
            chk("busy",     busy,     (k <= 8) || (k == 10));
            chk("core_gnt", core_gnt, k == 10);
            if (k == 1) ld_req = 1'b0;
            if (k == core_at) core_req = 1'b1;
        end
    endtask

    // Offer one byte, wait (bounded) for grant and completion
    task automatic send_byte(input logic [7:0] b);
        int n;
        push_exp(b, 8);
        ld_byte = b;
        ld_req  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ld_gnt && n < 30);
        chk("gnt_timeout", ld_gnt, 1);
        ld_req = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("busy_timeout", busy, 0);
    endtask

    task automatic core_release();
        core_req = 1'b0;
        @(negedge clk);
        chk("rel_core_gnt", core_gnt, 0);
        chk("rel_busy",     busy, 0);
    endtask

    // core read: grant one cycle later, data one cycle after the address
    task automatic core_read2(input logic [AW-1:0] a0, input logic d0,
                              input logic [AW-1:0] a1, input logic d1);
        core_req  = 1'b1;
        core_addr = a0;
        chk("cr_pre_gnt", core_gnt, 0);
        @(negedge clk);
        chk("cr_gnt",      core_gnt, 1);
        chk("cr_ram_addr", ram_addr, a0);
        chk("cr_ram_we",   ram_we, 0);
        ld_req  = 1'b1;              // loader must stall while core owns RAM
        ld_byte = 8'h00;
        @(negedge clk);
        chk("cr_q0",     core_q, d0);
        chk("cr_ld_gnt", ld_gnt, 0);
        core_addr = a1;
        @(negedge clk);
        chk("cr_q1",     core_q, d1);
        chk("cr_ld_gnt", ld_gnt, 0);
        ld_req = 1'b0;
        core_release();
    endtask

    initial begin : main
        rst       = 1'b1;
        ld_req    = 1'b0;
        ld_byte   = 8'h00;
        core_req  = 1'b0;
        core_addr = '0;
        repeat (2) @(negedge clk);
        chk("reset_ld_gnt",   ld_gnt, 0);
        chk("reset_core_gnt", core_gnt, 0);
        chk("reset_ram_we",   ram_we, 0);
        chk("reset_ram_addr", ram_addr, 0);
        chk("reset_ram_data", ram_data, 0);
        chk("reset_busy",     busy, 0);
        chk("reset_fd",       ld_frame_done, 0);
        rst = 1'b0;
        @(negedge clk);

        // 0xA5 -> addrs 0..7, data 1,0,1,0,0,1,0,1
        byte_core(8'hA5, -1);

`ifndef ARB_FRAME_LOCK_EN
        // core read of the partial image: addr 5 = 1, addr 6 = 0
        core_read2(AW'(5), 1'b1, AW'(6), 1'b0);

        // core_req raised on the 3rd write waits for the byte to finish
        byte_core(8'h5A, 3);
        core_release();

        // ties after reset: loader first, core next, loader again
        do_reset();
        byte_core(8'h3C, 0);
        core_release();
        byte_core(8'hC3, 0);
        core_release();
`endif

        // reset during the 4th write: partial byte, pointer restarts at 0
        push_exp(8'h6B, 4);
        ld_byte = 8'h6B;
        ld_req  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("mid_ram_we", ram_we, 1);
            if (k == 1) ld_req = 1'b0;
        end
        do_reset();
        send_byte(8'h81);

        // full frame of 0xFF, then 0x01 wraps to addr 0
        do_reset();
        for (int i = 0; i < NPIX/8; i++) begin
            send_byte(8'hFF);
`ifdef ARB_FRAME_LOCK_EN
            if (i == 9) core_req = 1'b1;
            if (i >= 10 && i < NPIX/8 - 1) chk("lock_no_gnt", core_gnt, 0);
`endif
        end
        chk("fd_count", fd_cnt, 1);
`ifdef ARB_FRAME_LOCK_EN
        @(negedge clk);
        chk("lock_gnt_at_frame", core_gnt, 1);
        core_release();
`endif
        send_byte(8'h01);
        chk("fd_count_after", fd_cnt, 1);
`ifndef ARB_FRAME_LOCK_EN
        core_read2(AW'(NPIX-1), 1'b1, AW'(1), 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
